// File: rtl/onehot_decoder_pkg.sv
// Shared types and encodings for the sequenced one-hot decoder.
package onehot_decoder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HOLD = 2'd1,
    SCAN = 2'd2
  } state_t;

  localparam logic MODE_DIRECT = 1'b0;
  localparam logic MODE_SCAN   = 1'b1;

endpackage

// File: rtl/onehot_decoder_dwell_cnt.sv
// Dwell counter: latches a dwell limit on load and flags the last cycle of each scan position.
module onehot_decoder_dwell_cnt #(
  parameter int unsigned DWELL_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clr,
  input  logic               load,
  input  logic               run,
  input  logic [DWELL_W-1:0] dwell,
  output logic               tc_c
);

  logic [DWELL_W-1:0] cnt;
  logic [DWELL_W-1:0] limit;

  assign tc_c = (cnt == limit);

  // Priority: reset, then clear (block disabled), then load, then count
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt   <= '0;
      limit <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (load) begin
      cnt   <= '0;
      limit <= dwell;
    end else if (run) begin
      cnt <= tc_c ? '0 : cnt + DWELL_W'(1);
    end
  end

endmodule

// File: rtl/onehot_decoder_seq.sv
// Registered N-to-2^N one-hot decoder with accept handshake, direct hold and auto-scan modes.
module onehot_decoder_seq
  import onehot_decoder_pkg::*;
#(
  parameter  int unsigned N       = 3,
  parameter  int unsigned DWELL_W = 8,
  localparam int unsigned M       = 1 << N
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic               mode,
  input  logic [N-1:0]       sel,
  input  logic [DWELL_W-1:0] dwell,
  input  logic               in_valid,
  output logic               in_ready,
  output logic [M-1:0]       q,
  output logic               q_valid,
  output logic [N-1:0]       idx,
  output logic               wrap
);

  state_t state;
  logic   accept_c;
  logic   tc_c;

  assign in_ready = en && (state != SCAN);
  assign accept_c = in_valid && in_ready;

  onehot_decoder_dwell_cnt #(
    .DWELL_W (DWELL_W)
  ) u_dwell_cnt (
    .clk   (clk),
    .rst   (rst),
    .clr   (!en),
    .load  (accept_c && (mode == MODE_SCAN)),
    .run   (state == SCAN),
    .dwell (dwell),
    .tc_c  (tc_c)
  );

  // FSM plus q/idx/wrap registers; priority rst > en low > accept > scan advance
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      q       <= '0;
      q_valid <= 1'b0;
      idx     <= '0;
      wrap    <= 1'b0;
    end else if (!en) begin
      state   <= IDLE;
      q       <= '0;
      q_valid <= 1'b0;
      wrap    <= 1'b0;
    end else if (accept_c) begin
      state   <= (mode == MODE_SCAN) ? SCAN : HOLD;
      q       <= M'(1) << sel;
      q_valid <= 1'b1;
      idx     <= sel;
      wrap    <= 1'b0;
    end else if ((state == SCAN) && tc_c) begin
      q    <= {q[M-2:0], q[M-1]};
      idx  <= idx + N'(1);
      wrap <= (idx == N'(M - 1));
    end else begin
      wrap <= 1'b0;
    end
  end

endmodule

// File: tb/tb_onehot_decoder_seq.sv
// Scoreboard bench for onehot_decoder_seq at N=3, N=4 and N=1.
module tb_onehot_decoder_seq;

  typedef struct {
    int          id;
    string       name;
    logic [15:0] q;
    logic [3:0]  idx;
    logic        qv;
    logic        wrap;
    logic        rdy;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en = 1'b0;
  logic       mode = 1'b0;
  logic [3:0] sel = '0;
  logic [7:0] dwell = '0;
  logic       iv3 = 1'b0, iv4 = 1'b0, iv1 = 1'b0;
  logic       done = 1'b0;

  logic        rdy3, qv3, wr3;
  logic [7:0]  q3;
  logic [2:0]  idx3;
  logic        rdy4, qv4, wr4;
  logic [15:0] q4;
  logic [3:0]  idx4;
  logic        rdy1, qv1, wr1;
  logic [1:0]  q1;
  logic [0:0]  idx1;

  exp_t sb[$];
  int   checks = 0;
  int   passes = 0;

  always #5 clk = ~clk;

  onehot_decoder_seq #(.N(3), .DWELL_W(8)) u3 (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .sel(sel[2:0]), .dwell(dwell),
    .in_valid(iv3), .in_ready(rdy3), .q(q3), .q_valid(qv3), .idx(idx3), .wrap(wr3));

  onehot_decoder_seq #(.N(4), .DWELL_W(8)) u4 (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .sel(sel), .dwell(dwell),
    .in_valid(iv4), .in_ready(rdy4), .q(q4), .q_valid(qv4), .idx(idx4), .wrap(wr4));

  onehot_decoder_seq #(.N(1), .DWELL_W(8)) u1 (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .sel(sel[0:0]), .dwell(dwell),
    .in_valid(iv1), .in_ready(rdy1), .q(q1), .q_valid(qv1), .idx(idx1), .wrap(wr1));

  // Monitor: pop one expectation per cycle and compare against the addressed DUT
  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t        e;
      logic [15:0] aq;
      logic [3:0]  ai;
      logic        av, aw, ar;
      e = sb.pop_front();
      case (e.id)
        4:       begin aq = q4;         ai = idx4;        av = qv4; aw = wr4; ar = rdy4; end
        1:       begin aq = 16'(q1);    ai = 4'(idx1);    av = qv1; aw = wr1; ar = rdy1; end
        default: begin aq = 16'(q3);    ai = 4'(idx3);    av = qv3; aw = wr3; ar = rdy3; end
      endcase
      checks++;
      if (aq === e.q && ai === e.idx && av === e.qv && aw === e.wrap && ar === e.rdy)
        passes++;
      else
        $display("FAIL %s (N-id %0d): got q=%h idx=%0d qv=%b wrap=%b rdy=%b, want q=%h idx=%0d qv=%b wrap=%b rdy=%b",
                 e.name, e.id, aq, ai, av, aw, ar, e.q, e.idx, e.qv, e.wrap, e.rdy);
    end
  end

  // Invariant: q is zero when invalid, otherwise exactly 1<<idx
  always @(negedge clk) begin
    if (!rst && !done) begin
      checks++;
      if (((qv3 && q3 === (8'd1 << idx3)) || (!qv3 && q3 === 8'd0)) &&
          ((qv4 && q4 === (16'd1 << idx4)) || (!qv4 && q4 === 16'd0)) &&
          ((qv1 && q1 === (2'd1 << idx1)) || (!qv1 && q1 === 2'd0)))
        passes++;
      else
        $display("FAIL invariant: q3=%h/%0d/%b q4=%h/%0d/%b q1=%h/%0d/%b",
                 q3, idx3, qv3, q4, idx4, qv4, q1, idx1, qv1);
    end
  end

  // Watchdog: the stimulus must finish within a bounded wait
  initial begin
    #20000;
    if (!done) begin
      $display("FAIL timeout: stimulus did not complete");
      $finish;
    end
  end

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
    #1;
  endtask

  task automatic tick_exp(input int id, input string name, input logic [15:0] q,
                          input logic [3:0] idx, input logic qv, input logic wrap,
                          input logic rdy);
    exp_t e;
    @(posedge clk);
    #1;
    e.id = id; e.name = name; e.q = q; e.idx = idx;
    e.qv = qv; e.wrap = wrap; e.rdy = rdy;
    sb.push_back(e);
    @(negedge clk);
    #1;
  endtask

  initial begin
    // Reset
    rst = 1'b1; en = 1'b1;
    tick_exp(3, "reset", 16'h0000, 4'd0, 1'b0, 1'b0, 1'b1);

    // Reset state of every instance
    checks++;
    if (q3 === 8'd0 && qv3 === 1'b0 && idx3 === 3'd0 && wr3 === 1'b0 && rdy3 === 1'b1 &&
        q4 === 16'd0 && qv4 === 1'b0 && idx4 === 4'd0 && wr4 === 1'b0 && rdy4 === 1'b1 &&
        q1 === 2'd0 && qv1 === 1'b0 && idx1 === 1'd0 && wr1 === 1'b0 && rdy1 === 1'b1)
      passes++;
    else
      $display("FAIL reset_state: q3=%h qv3=%b idx3=%0d q4=%h qv4=%b idx4=%0d q1=%h qv1=%b idx1=%0d",
               q3, qv3, idx3, q4, qv4, idx4, q1, qv1, idx1);
    rst = 1'b0;

    // Direct decode, back-to-back accepts
    mode = 1'b0; iv3 = 1'b1;
    for (int s = 0; s < 8; s++) begin
      sel = 4'(s);
      tick_exp(3, "direct", 16'h0001 << s, 4'(s), 1'b1, 1'b0, 1'b1);
    end
    iv3 = 1'b0;
    tick_exp(3, "direct_hold", 16'h0080, 4'd7, 1'b1, 1'b0, 1'b1);

    // Scan sel=6 dwell=2; later sel/dwell/in_valid changes must be ignored
    sel = 4'd6; mode = 1'b1; dwell = 8'd2; iv3 = 1'b1;
    tick_exp(3, "scan6_first", 16'h0040, 4'd6, 1'b1, 1'b0, 1'b0);
    sel = 4'd1; dwell = 8'd7; mode = 1'b0;
    tick_exp(3, "scan6_dwell", 16'h0040, 4'd6, 1'b1, 1'b0, 1'b0);
    iv3 = 1'b0;
    tick_exp(3, "scan6_dwell", 16'h0040, 4'd6, 1'b1, 1'b0, 1'b0);
    tick_exp(3, "scan6_to7", 16'h0080, 4'd7, 1'b1, 1'b0, 1'b0);
    tick_exp(3, "scan6_at7", 16'h0080, 4'd7, 1'b1, 1'b0, 1'b0);
    tick_exp(3, "scan6_at7", 16'h0080, 4'd7, 1'b1, 1'b0, 1'b0);
    tick_exp(3, "scan6_wrap", 16'h0001, 4'd0, 1'b1, 1'b1, 1'b0);
    tick_exp(3, "scan6_at0", 16'h0001, 4'd0, 1'b1, 1'b0, 1'b0);
    tick_exp(3, "scan6_at0", 16'h0001, 4'd0, 1'b1, 1'b0, 1'b0);
    tick_exp(3, "scan6_to1", 16'h0002, 4'd1, 1'b1, 1'b0, 1'b0);

    // Disable leaves SCAN, idx retained
    en = 1'b0;
    tick_exp(3, "en_off", 16'h0000, 4'd1, 1'b0, 1'b0, 1'b0);
    en = 1'b1;

    // Scan sel=0 dwell=0: rotate every cycle, wrap every 8
    sel = 4'd0; mode = 1'b1; dwell = 8'd0; iv3 = 1'b1;
    tick_exp(3, "scan0_first", 16'h0001, 4'd0, 1'b1, 1'b0, 1'b0);
    iv3 = 1'b0;
    for (int k = 1; k <= 19; k++)
      tick_exp(3, "scan0_step", 16'h0001 << (k % 8), 4'(k % 8), 1'b1, 1'b1 ? ((k % 8) == 0) : 1'b0, 1'b0);

    // en drop at idx=3 with a simultaneous request that must not be accepted
    en = 1'b0; iv3 = 1'b1; mode = 1'b0; sel = 4'd5;
    tick_exp(3, "en_drop", 16'h0000, 4'd3, 1'b0, 1'b0, 1'b0);
    en = 1'b1; iv3 = 1'b0;
    tick_exp(3, "en_back_idle", 16'h0000, 4'd3, 1'b0, 1'b0, 1'b1);

    // Synchronous reset mid-scan, then a direct accept
    sel = 4'd4; mode = 1'b1; dwell = 8'd5; iv3 = 1'b1;
    tick_exp(3, "scan4_first", 16'h0010, 4'd4, 1'b1, 1'b0, 1'b0);
    iv3 = 1'b0;
    tick_exp(3, "scan4_dwell", 16'h0010, 4'd4, 1'b1, 1'b0, 1'b0);
    rst = 1'b1;
    tick_exp(3, "rst_mid_scan", 16'h0000, 4'd0, 1'b0, 1'b0, 1'b1);
    rst = 1'b0; mode = 1'b0; sel = 4'd2; iv3 = 1'b1;
    tick_exp(3, "post_rst_direct", 16'h0004, 4'd2, 1'b1, 1'b0, 1'b1);
    iv3 = 1'b0;

    // N=4: direct, then scan from 14 with dwell=1 across the wrap
    sel = 4'd9; mode = 1'b0; iv4 = 1'b1;
    tick_exp(4, "n4_direct", 16'h0200, 4'd9, 1'b1, 1'b0, 1'b1);
    sel = 4'd14; mode = 1'b1; dwell = 8'd1;
    tick_exp(4, "n4_scan_first", 16'h4000, 4'd14, 1'b1, 1'b0, 1'b0);
    iv4 = 1'b0;
    tick_exp(4, "n4_scan_14", 16'h4000, 4'd14, 1'b1, 1'b0, 1'b0);
    tick_exp(4, "n4_scan_15", 16'h8000, 4'd15, 1'b1, 1'b0, 1'b0);
    tick_exp(4, "n4_scan_15", 16'h8000, 4'd15, 1'b1, 1'b0, 1'b0);
    tick_exp(4, "n4_wrap", 16'h0001, 4'd0, 1'b1, 1'b1, 1'b0);
    tick_exp(4, "n4_scan_0", 16'h0001, 4'd0, 1'b1, 1'b0, 1'b0);
    tick_exp(4, "n4_scan_1", 16'h0002, 4'd1, 1'b1, 1'b0, 1'b0);
    en = 1'b0;
    tick();
    en = 1'b1;

    // N=1: direct both codes, then scan dwell=0
    sel = 4'd1; mode = 1'b0; iv1 = 1'b1;
    tick_exp(1, "n1_direct1", 16'h0002, 4'd1, 1'b1, 1'b0, 1'b1);
    sel = 4'd0;
    tick_exp(1, "n1_direct0", 16'h0001, 4'd0, 1'b1, 1'b0, 1'b1);
    sel = 4'd1; mode = 1'b1; dwell = 8'd0;
    tick_exp(1, "n1_scan_first", 16'h0002, 4'd1, 1'b1, 1'b0, 1'b0);
    iv1 = 1'b0;
    tick_exp(1, "n1_wrap", 16'h0001, 4'd0, 1'b1, 1'b1, 1'b0);
    tick_exp(1, "n1_scan_1", 16'h0002, 4'd1, 1'b1, 1'b0, 1'b0);
    tick_exp(1, "n1_wrap2", 16'h0001, 4'd0, 1'b1, 1'b1, 1'b0);

    tick();
    done = 1'b1;
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
